logic_axi4_stream_demux: RTL and testbench
==========================================

Name: logic_axi4_stream_demux

Overview:
AXI4-Stream 1-to-N demultiplexer with flat port lists. It routes each packet from a single Rx stream to one of OUTPUTS Tx streams, selected by TDEST on the first beat of the packet. Each output has its own one-deep register stage, so backpressure on one output never stalls a transfer already held on another. It is the distribution-side counterpart of the N-to-1 stream mux and sits ahead of per-destination processing.

Parameters:
OUTPUTS, 16, number of Tx streams (>= 2).
TDATA_BYTES, 4, TDATA width in bytes.
TDEST_WIDTH, 4, TDEST width; must satisfy 2**TDEST_WIDTH >= OUTPUTS.
TUSER_WIDTH, 1, TUSER width.
TID_WIDTH, 1, TID width.
TLAST, 1, 1 = packet-locked routing; 0 = every beat routed independently by its own TDEST.

Ports:
aclk  input  1  clock; all logic on the rising edge.
areset_n  input  1  asynchronous active-low reset.
rx_tvalid  input  1  Rx valid.
rx_tlast  input  1  Rx end of packet.
rx_tdata  input  TDATA_BYTES*8  Rx data.
rx_tstrb  input  TDATA_BYTES  Rx byte strobe.
rx_tkeep  input  TDATA_BYTES  Rx byte keep.
rx_tdest  input  TDEST_WIDTH  Rx destination; selects the output.
rx_tuser  input  TUSER_WIDTH  Rx user sideband.
rx_tid  input  TID_WIDTH  Rx stream ID.
rx_tready  output  1  Rx ready.
tx_tvalid  output  OUTPUTS  per-output valid.
tx_tlast  output  OUTPUTS  per-output last.
tx_tdata  output  OUTPUTS x TDATA_BYTES*8  per-output data.
tx_tstrb, tx_tkeep  output  OUTPUTS x TDATA_BYTES  per-output strobe and keep.
tx_tdest  output  OUTPUTS x TDEST_WIDTH  per-output TDEST; the original value, passed through unchanged.
tx_tuser  output  OUTPUTS x TUSER_WIDTH  per-output user sideband.
tx_tid  output  OUTPUTS x TID_WIDTH  per-output stream ID.
tx_tready  input  OUTPUTS  per-output ready.
dropped  output  1  one-cycle pulse for each Rx beat that is accepted and discarded.

Behaviour:
- Reset (areset_n low, asynchronous): all tx_* = 0, tx_tvalid = 0, dropped = 0, FSM = IDLE, sel_q = 0. The module leaves reset cleanly on the first rising edge after areset_n goes high.
- Select: in IDLE (or whenever TLAST=0), sel = rx_tdest. In PACKET, sel = sel_q and rx_tdest is ignored.
- Valid range: sel < OUTPUTS is in range. sel >= OUTPUTS is out of range and the beat is dropped.
- rx_tready (combinational):
  - In range: ~tx_tvalid[sel] | tx_tready[sel].
  - Out of range: 1.
  - It does not depend on rx_tvalid.
- Accept condition: rx_tvalid & rx_tready.
  - In range: the output register for sel loads all Rx fields and sets tx_tvalid[sel] = 1 on the next edge. Latency is 1 cycle.
  - Out of range: the beat is discarded and dropped = 1 for the next cycle.
- Output register k:
  - tx_tvalid[k] clears on tx_tvalid[k] & tx_tready[k] unless it is reloaded in the same cycle.
  - Simultaneous drain and load is allowed, giving 1 beat/cycle per output.
  - Fields are held stable while tx_tvalid[k] & ~tx_tready[k] (AXI-compliant).
- FSM (TLAST=1 only):
  - IDLE -> PACKET on an accepted beat with rx_tlast=0; sel_q <= rx_tdest.
  - PACKET -> IDLE on an accepted beat with rx_tlast=1.
  - An accepted single-beat packet (tlast=1) in IDLE stays in IDLE.
  - Out-of-range packets also lock, so every beat of that packet is dropped even if later TDEST values are in range.
- TLAST=0: no FSM; every beat is routed by its own rx_tdest.
- Independence: an output stalled by tx_tready[k]=0 blocks Rx only when sel == k. Other outputs keep draining their registered beats.
- No reordering within an output. Beats to different outputs may leave in any relative order.
- dropped is a registered pulse that is high exactly one cycle per discarded beat. It is asserted on back-to-back cycles for consecutive drops.

Test Plan:
- Single beat, tdest=2, tdata=0xA5A5A5A5, tlast=1, all tx_tready=1 -> tx_tvalid=0x0004 one cycle later with tdata=0xA5A5A5A5; rx_tready stays 1; FSM remains IDLE.
- 3-beat packet with tdest 1, 7, 9 on successive beats -> all 3 beats appear on output 1 in order, tx_tdest=1,7,9; nothing appears on outputs 7 or 9.
- Output 3 with tx_tready[3]=0 and 2 beats to dest 3 -> first beat is registered and rx_tready=0 on the second; packet to dest 5 is blocked behind it. Releasing tx_tready[3] drains both beats, after which dest 5 flows.
- OUTPUTS=12, tdest=13, 2-beat packet -> rx_tready=1, no tx_tvalid, dropped high for 2 cycles. Next packet to dest 0 is delivered normally.
- Reset asserted mid-packet (after beat 1 of 3 to dest 4) -> tx_tvalid=0 immediately and FSM=IDLE. A new packet to dest 6 afterwards routes to output 6.
- TLAST=0, consecutive beats with tdest 0, 1, 0, all ready -> one beat each on outputs 0, 1, 0 at 1 beat/cycle, no lock.

Source files
------------

// File: rtl/logic_axi4_stream_demux.sv
//------------------------------------------------------------------------------
// logic_axi4_stream_demux
// AXI4-Stream 1-to-N demultiplexer, TDEST-routed, one register slice per output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module logic_axi4_stream_demux #(
    parameter int OUTPUTS     = 16,
    parameter int TDATA_BYTES = 4,
    parameter int TDEST_WIDTH = 4,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int TLAST       = 1
) (
    input  logic                               aclk,
    input  logic                               areset_n,
    input  logic                               rx_tvalid,
    input  logic                               rx_tlast,
    input  logic [TDATA_BYTES*8-1:0]           rx_tdata,
    input  logic [TDATA_BYTES-1:0]             rx_tstrb,
    input  logic [TDATA_BYTES-1:0]             rx_tkeep,
    input  logic [TDEST_WIDTH-1:0]             rx_tdest,
    input  logic [TUSER_WIDTH-1:0]             rx_tuser,
    input  logic [TID_WIDTH-1:0]               rx_tid,
    output logic                               rx_tready,
    output logic [OUTPUTS-1:0]                 tx_tvalid,
    output logic [OUTPUTS-1:0]                 tx_tlast,
    output logic [OUTPUTS*TDATA_BYTES*8-1:0]   tx_tdata,
    output logic [OUTPUTS*TDATA_BYTES-1:0]     tx_tstrb,
    output logic [OUTPUTS*TDATA_BYTES-1:0]     tx_tkeep,
    output logic [OUTPUTS*TDEST_WIDTH-1:0]     tx_tdest,
    output logic [OUTPUTS*TUSER_WIDTH-1:0]     tx_tuser,
    output logic [OUTPUTS*TID_WIDTH-1:0]       tx_tid,
    input  logic [OUTPUTS-1:0]                 tx_tready,
    output logic                               dropped
);

    localparam int                    c_DATA_W  = TDATA_BYTES * 8;
    localparam logic [TDEST_WIDTH:0]  c_OUT_LIM = (TDEST_WIDTH + 1)'(OUTPUTS);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_PACKET = 1'b1
    } state_t;

    state_t                   r_state;
    logic [TDEST_WIDTH-1:0]   r_sel_q;
    logic                     r_dropped;

    logic [TDEST_WIDTH-1:0]   w_sel;
    logic                     w_in_range;
    logic                     w_accept;
    logic [OUTPUTS-1:0]       w_hit;
    logic [OUTPUTS-1:0]       w_slot_free;
    logic [OUTPUTS-1:0]       w_tx_valid;

    // The state only leaves IDLE when packet locking is enabled.
    assign w_sel      = (r_state == S_PACKET) ? r_sel_q : rx_tdest;
    assign w_in_range = ({1'b0, w_sel} < c_OUT_LIM);
    assign w_slot_free = ~w_tx_valid | tx_tready;
    assign rx_tready  = w_in_range ? |(w_hit & w_slot_free) : 1'b1;
    assign w_accept   = rx_tvalid & rx_tready;
    assign tx_tvalid  = w_tx_valid;
    assign dropped    = r_dropped;

    generate
        for (genvar k = 0; k < OUTPUTS; k++) begin : g_out
            logic                    r_valid;
            logic                    r_last;
            logic [c_DATA_W-1:0]     r_data;
            logic [TDATA_BYTES-1:0]  r_strb;
            logic [TDATA_BYTES-1:0]  r_keep;
            logic [TDEST_WIDTH-1:0]  r_dest;
            logic [TUSER_WIDTH-1:0]  r_user;
            logic [TID_WIDTH-1:0]    r_id;
            logic                    w_load;

            assign w_hit[k] = (w_sel == TDEST_WIDTH'(k));
            assign w_load   = w_accept & w_hit[k];

            always_ff @(posedge aclk or negedge areset_n) begin
                if (!areset_n) begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_data  <= '0;
                    r_strb  <= '0;
                    r_keep  <= '0;
                    r_dest  <= '0;
                    r_user  <= '0;
                    r_id    <= '0;
                end else if (w_load) begin
                    r_valid <= 1'b1;
                    r_last  <= rx_tlast;
                    r_data  <= rx_tdata;
                    r_strb  <= rx_tstrb;
                    r_keep  <= rx_tkeep;
                    r_dest  <= rx_tdest;
                    r_user  <= rx_tuser;
                    r_id    <= rx_tid;
                end else if (tx_tready[k]) begin
                    r_valid <= 1'b0;
                end
            end

            assign w_tx_valid[k]                            = r_valid;
            assign tx_tlast[k]                              = r_last;
            assign tx_tdata[k*c_DATA_W +: c_DATA_W]         = r_data;
            assign tx_tstrb[k*TDATA_BYTES +: TDATA_BYTES]   = r_strb;
            assign tx_tkeep[k*TDATA_BYTES +: TDATA_BYTES]   = r_keep;
            assign tx_tdest[k*TDEST_WIDTH +: TDEST_WIDTH]   = r_dest;
            assign tx_tuser[k*TUSER_WIDTH +: TUSER_WIDTH]   = r_user;
            assign tx_tid[k*TID_WIDTH +: TID_WIDTH]         = r_id;
        end
    endgenerate

    // Out-of-range packets lock too, so their tail beats are dropped as well.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= S_IDLE;
            r_sel_q <= '0;
        end else if ((TLAST != 0) && w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (!rx_tlast) begin
                        r_state <= S_PACKET;
                        r_sel_q <= rx_tdest;
                    end
                end
                S_PACKET: begin
                    if (rx_tlast) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_accept & ~w_in_range;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_logic_axi4_stream_demux.sv
//------------------------------------------------------------------------------
// tb_logic_axi4_stream_demux
// Scoreboard bench: instance 0 packet-locked, instance 1 per-beat routing.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_logic_axi4_stream_demux;

    localparam int c_N = 12;
    typedef logic [46:0] beat_t;

    logic clk = 1'b0;
    logic areset_n;

    logic                 rx_tvalid [2];
    logic                 rx_tlast  [2];
    logic [31:0]          rx_tdata  [2];
    logic [3:0]           rx_tstrb  [2];
    logic [3:0]           rx_tkeep  [2];
    logic [3:0]           rx_tdest  [2];
    logic [0:0]           rx_tuser  [2];
    logic [0:0]           rx_tid    [2];
    logic                 rx_tready [2];
    logic [c_N-1:0]       tx_tvalid [2];
    logic [c_N-1:0]       tx_tlast  [2];
    logic [c_N*32-1:0]    tx_tdata  [2];
    logic [c_N*4-1:0]     tx_tstrb  [2];
    logic [c_N*4-1:0]     tx_tkeep  [2];
    logic [c_N*4-1:0]     tx_tdest  [2];
    logic [c_N-1:0]       tx_tuser  [2];
    logic [c_N-1:0]       tx_tid    [2];
    logic [c_N-1:0]       tx_tready [2];
    logic                 dropped   [2];

    generate
        for (genvar d = 0; d < 2; d++) begin : g_dut
            logic_axi4_stream_demux #(
                .OUTPUTS(c_N), .TDATA_BYTES(4), .TDEST_WIDTH(4),
                .TUSER_WIDTH(1), .TID_WIDTH(1), .TLAST((d == 0) ? 1 : 0)
            ) u_dut (
                .aclk(clk), .areset_n(areset_n),
                .rx_tvalid(rx_tvalid[d]), .rx_tlast(rx_tlast[d]), .rx_tdata(rx_tdata[d]),
                .rx_tstrb(rx_tstrb[d]), .rx_tkeep(rx_tkeep[d]), .rx_tdest(rx_tdest[d]),
                .rx_tuser(rx_tuser[d]), .rx_tid(rx_tid[d]), .rx_tready(rx_tready[d]),
                .tx_tvalid(tx_tvalid[d]), .tx_tlast(tx_tlast[d]), .tx_tdata(tx_tdata[d]),
                .tx_tstrb(tx_tstrb[d]), .tx_tkeep(tx_tkeep[d]), .tx_tdest(tx_tdest[d]),
                .tx_tuser(tx_tuser[d]), .tx_tid(tx_tid[d]), .tx_tready(tx_tready[d]),
                .dropped(dropped[d])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    beat_t       exp_q [2][c_N][$];
    int          drop_pend [2];
    bit          in_pkt [2];
    logic [3:0]  lock_dest [2];
    bit          rand_rdy [2];
    logic [c_N-1:0] hold [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t rx_beat(input int d);
        return {rx_tlast[d], rx_tdata[d], rx_tstrb[d], rx_tkeep[d], rx_tdest[d], rx_tuser[d], rx_tid[d]};
    endfunction

    function automatic beat_t tx_beat(input int d, input int k);
        return {tx_tlast[d][k], tx_tdata[d][k*32 +: 32], tx_tstrb[d][k*4 +: 4],
                tx_tkeep[d][k*4 +: 4], tx_tdest[d][k*4 +: 4], tx_tuser[d][k], tx_tid[d][k]};
    endfunction

    // Destination a beat should go to: locked packet destination or its own TDEST.
    function automatic int route(input int d);
        if (d == 0 && in_pkt[d]) return int'(lock_dest[d]);
        return int'(rx_tdest[d]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            in_pkt[d] = 1'b0;
            lock_dest[d] = 4'd0;
            drop_pend[d] = 0;
            for (int k = 0; k < c_N; k++) exp_q[d][k].delete();
        end
    endtask

    // Present one beat from posedge+1 and hold it until the handshake completes.
    task automatic send_beat(input int d, input logic [3:0] dest, input logic last, input logic [31:0] data);
        int r;
        bit ok;
        rx_tvalid[d] = 1'b1;
        rx_tlast[d]  = last;
        rx_tdata[d]  = data;
        rx_tstrb[d]  = 4'($urandom);
        rx_tkeep[d]  = 4'($urandom);
        rx_tdest[d]  = dest;
        rx_tuser[d]  = 1'($urandom);
        rx_tid[d]    = 1'($urandom);
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            r = route(d);
            if (r >= c_N) check("ready_out_of_range", 64'(rx_tready[d]), 64'd1);
            if (rx_tready[d]) begin
                ok = 1'b1;
                if (r < c_N) exp_q[d][r].push_back(rx_beat(d));
                else drop_pend[d]++;
                if (d == 0) begin
                    if (!in_pkt[d] && !last) begin
                        in_pkt[d] = 1'b1;
                        lock_dest[d] = dest;
                    end else if (in_pkt[d] && last) begin
                        in_pkt[d] = 1'b0;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int d);
        rx_tvalid[d] = 1'b0;
    endtask

    task automatic rand_run(input int d, input int beats);
        for (int i = 0; i < beats; i++) begin
            send_beat(d, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 4) == 0) begin
                idle(d);
                @(posedge clk);
                #1;
            end
        end
        idle(d);
    endtask

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++)
            tx_tready[d] = (rand_rdy[d] ? c_N'($urandom) : {c_N{1'b1}}) & ~hold[d];
    end

    // Monitor: every completed output handshake and every drop pulse is checked.
    always @(negedge clk) begin
        if (areset_n === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < c_N; k++) begin
                    if (tx_tvalid[d][k] && tx_tready[d][k]) begin
                        if (exp_q[d][k].size() == 0) begin
                            check($sformatf("unexpected_beat_d%0d_o%0d", d, k), 64'(tx_beat(d, k)), 64'd0);
                        end else begin
                            check($sformatf("beat_d%0d_o%0d", d, k), 64'(tx_beat(d, k)),
                                  64'(exp_q[d][k].pop_front()));
                        end
                    end
                end
                if (dropped[d]) begin
                    check($sformatf("drop_expected_d%0d", d), 64'(drop_pend[d] > 0), 64'd1);
                    if (drop_pend[d] > 0) drop_pend[d]--;
                end
            end
        end
    end

    function automatic bit all_empty();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < c_N; k++)
                if (exp_q[d][k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        time t0;
        areset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rx_tvalid[d] = 1'b0; rx_tlast[d] = 1'b0; rx_tdata[d] = '0; rx_tstrb[d] = '0;
            rx_tkeep[d] = '0; rx_tdest[d] = '0; rx_tuser[d] = '0; rx_tid[d] = '0;
            tx_tready[d] = {c_N{1'b1}}; hold[d] = '0; rand_rdy[d] = 1'b0;
        end
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_tvalid", 64'(tx_tvalid[d]), 64'd0);
            check("reset_tdata", 64'(tx_tdata[d][63:0]), 64'd0);
            check("reset_dropped", 64'(dropped[d]), 64'd0);
        end
        repeat (3) @(posedge clk);
        #2 areset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", 64'(rx_tready[0]), 64'd1);

        // Single beat to output 2.
        send_beat(0, 4'd2, 1'b1, 32'hA5A5A5A5);
        idle(0);
        @(negedge clk);
        check("single_tvalid", 64'(tx_tvalid[0]), 64'h004);
        check("single_tdata", 64'(tx_tdata[0][2*32 +: 32]), 64'hA5A5A5A5);
        check("single_ready", 64'(rx_tready[0]), 64'd1);
        @(posedge clk); #1;

        // Packet locked to output 1 despite changing TDEST.
        send_beat(0, 4'd1, 1'b0, 32'h11111111);
        send_beat(0, 4'd7, 1'b0, 32'h22222222);
        send_beat(0, 4'd9, 1'b1, 32'h33333333);
        idle(0);
        repeat (3) @(posedge clk); #1;

        // Output 3 stalled: second beat blocks, later packet to 5 waits behind it.
        hold[0] = 12'h008;
        repeat (2) @(posedge clk); #1;
        fork
            begin
                send_beat(0, 4'd3, 1'b0, 32'h30303030);
                send_beat(0, 4'd3, 1'b1, 32'h31313131);
                send_beat(0, 4'd5, 1'b1, 32'h50505050);
                idle(0);
            end
            begin
                repeat (6) @(negedge clk);
                check("stall_ready", 64'(rx_tready[0]), 64'd0);
                check("stall_out3_valid", 64'(tx_tvalid[0][3]), 64'd1);
                check("stall_out5_idle", 64'(tx_tvalid[0][5]), 64'd0);
                hold[0] = '0;
            end
        join
        repeat (3) @(posedge clk); #1;

        // Out-of-range packet is dropped entirely, then dest 0 flows.
        send_beat(0, 4'd13, 1'b0, 32'hDEAD0001);
        send_beat(0, 4'd13, 1'b1, 32'hDEAD0002);
        idle(0);
        @(negedge clk);
        check("drop_no_tvalid", 64'(tx_tvalid[0]), 64'd0);
        @(posedge clk); #1;
        send_beat(0, 4'd0, 1'b1, 32'h0000C0DE);
        idle(0);
        repeat (3) @(posedge clk); #1;

        // Reset mid-packet with the first beat parked on output 4.
        hold[0] = 12'h010;
        @(posedge clk); #1;
        send_beat(0, 4'd4, 1'b0, 32'h44444444);
        idle(0);
        #2 areset_n = 1'b0;
        #1;
        check("midreset_tvalid", 64'(tx_tvalid[0]), 64'd0);
        check("midreset_dropped", 64'(dropped[0]), 64'd0);
        model_reset();
        hold[0] = '0;
        repeat (2) @(posedge clk);
        #2 areset_n = 1'b1;
        @(posedge clk); #1;
        send_beat(0, 4'd6, 1'b1, 32'h66666666);
        idle(0);
        repeat (3) @(posedge clk); #1;

        // Per-beat routing instance: 0, 1, 0 back to back at full rate.
        t0 = $time;
        send_beat(1, 4'd0, 1'b0, 32'hB0000000);
        send_beat(1, 4'd1, 1'b0, 32'hB1111111);
        send_beat(1, 4'd0, 1'b0, 32'hB2222222);
        idle(1);
        check("nolock_rate_cycles", 64'(($time - t0) / 10), 64'd3);
        repeat (3) @(posedge clk); #1;

        rand_rdy[0] = 1'b1;
        rand_rdy[1] = 1'b1;
        fork
            rand_run(0, 300);
            rand_run(1, 300);
        join
        rand_rdy[0] = 1'b0;
        rand_rdy[1] = 1'b0;
        for (int t = 0; t < 200 && !all_empty(); t++) @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("drain_queues_empty", 64'(all_empty()), 64'd1);
        check("drain_drops_d0", 64'(drop_pend[0]), 64'd0);
        check("drain_drops_d1", 64'(drop_pend[1]), 64'd0);
        check("drain_tvalid_d0", 64'(tx_tvalid[0]), 64'd0);
        check("drain_tvalid_d1", 64'(tx_tvalid[1]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
